// File: rtl/jt12_i2s_tx.sv
// I2S / left-justified serial transmitter for the jt12 stereo output.
// A sample pair is captured into hold registers. At each frame boundary it is moved
// into the shift registers (cur_l/cur_r). With no new pair, the last frame is repeated.
// Bit timing comes from clk_en ticks: bclk toggles every DIV ticks.
// sdo and lrck change only on bclk falling events.
module jt12_i2s_tx #(
    parameter int unsigned DIV = 2,
    parameter int unsigned FMT = 1
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        clk_en,
    input  logic        sample,
    input  logic [15:0] left,
    input  logic [15:0] right,
    output logic        bclk,
    output logic        lrck,
    output logic        sdo,
    output logic        frame_start,
    output logic        overrun
);

    localparam logic [7:0] DivLast = 8'(DIV - 1);

    // Bit-clock divider
    logic [7:0] div_q, div_d;
    logic       bclk_q, bclk_d;
    logic       div_wrap;
    logic       fall;

    // Frame position and serializer
    logic [4:0] bitcnt_q, bitcnt_d;
    logic       lrck_q, lrck_d;
    logic       sdo_q, sdo_d;
    logic [15:0] cur_l_q, cur_l_d;
    logic [15:0] cur_r_q, cur_r_d;
    logic       frame_wrap;
    logic       load;
    logic [3:0] bit_sel;
    logic [4:0] next_slot;

    // Sample capture and status
    logic [15:0] hold_l_q, hold_l_d;
    logic [15:0] hold_r_q, hold_r_d;
    logic        pending_q, pending_d;
    logic        overrun_q, overrun_d;
    logic        fs_q, fs_d;

    // Divider next state: count ticks 0..DIV-1 and toggle bclk on the last one
    always_comb begin
        div_wrap = (div_q == DivLast);
        div_d    = div_wrap ? 8'd0 : div_q + 8'd1;
        bclk_d   = bclk_q ^ div_wrap;
        // A toggle while bclk is high is a falling edge
        fall     = div_wrap & bclk_q;
    end

    // Frame sequencing: advance bitcnt and reload the shift data at slot 0
    always_comb begin
        bitcnt_d   = fall ? bitcnt_q + 5'd1 : bitcnt_q;
        frame_wrap = fall & (bitcnt_q == 5'd31);
        load       = frame_wrap & pending_q;
        cur_l_d    = load ? hold_l_q : cur_l_q;
        cur_r_d    = load ? hold_r_q : cur_r_q;
    end

    // Serializer next state: MSB first, left word in slots 0..15, right in 16..31
    always_comb begin
        bit_sel   = ~bitcnt_d[3:0];
        next_slot = bitcnt_d + 5'd1;
        sdo_d     = sdo_q;
        lrck_d    = lrck_q;
        if (fall) begin
            sdo_d = bitcnt_d[4] ? cur_r_d[bit_sel] : cur_l_d[bit_sel];
            // I2S moves word select one bit ahead of the data it frames
            lrck_d = (FMT == 0) ? bitcnt_d[4] : next_slot[4];
        end
    end

    // Capture next state: a load and a new sample on the same tick keep the new pair pending
    always_comb begin
        hold_l_d  = sample ? left : hold_l_q;
        hold_r_d  = sample ? right : hold_r_q;
        pending_d = sample | (pending_q & ~load);
        // Only an unsent pair being replaced counts as overrun
        overrun_d = overrun_q | (sample & pending_q & ~load);
        fs_d      = load;
    end

    // Divider and bit-clock registers
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= 8'd0;
            bclk_q <= 1'b0;
        end else if (clk_en) begin
            div_q  <= div_d;
            bclk_q <= bclk_d;
        end
    end

    // Frame position and serializer registers; bitcnt starts at 31 so the first fall is slot 0
    always_ff @(posedge clk) begin
        if (rst) begin
            bitcnt_q <= 5'd31;
            lrck_q   <= 1'b0;
            sdo_q    <= 1'b0;
            cur_l_q  <= 16'd0;
            cur_r_q  <= 16'd0;
        end else if (clk_en) begin
            bitcnt_q <= bitcnt_d;
            lrck_q   <= lrck_d;
            sdo_q    <= sdo_d;
            cur_l_q  <= cur_l_d;
            cur_r_q  <= cur_r_d;
        end
    end

    // Hold registers and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_l_q  <= 16'd0;
            hold_r_q  <= 16'd0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            fs_q      <= 1'b0;
        end else if (clk_en) begin
            hold_l_q  <= hold_l_d;
            hold_r_q  <= hold_r_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            fs_q      <= fs_d;
        end
    end

    // frame_start is qualified by clk_en so it is seen on exactly one enabled tick
    always_comb begin
        bclk        = bclk_q;
        lrck        = lrck_q;
        sdo         = sdo_q;
        overrun     = overrun_q;
        frame_start = fs_q & clk_en;
    end

endmodule

// File: doc/jt12_i2s_tx.md
JT12_I2S_TX -- requirements
Module: jt12_i2s_tx

Interface
REQ-001 SHALL have parameter DIV, default 2, meaning clk_en ticks per bclk half-period (legal 1..255).
REQ-002 SHALL have parameter FMT, default 1, meaning 1 = I2S (lrck leads data by one bit), 0 = left-justified.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port clk_en  input  1  clock enable; state advances only when high, except reset.
REQ-006 SHALL have port sample  input  1  strobe marking left/right as a new valid sample pair.
REQ-007 SHALL have port left  input  16  signed left sample from the channel accumulator stage.
REQ-008 SHALL have port right  input  16  signed right sample from the channel accumulator stage.
REQ-009 SHALL have port bclk  output  1  serial bit clock.
REQ-010 SHALL have port lrck  output  1  word select; 0 = left word, 1 = right word.
REQ-011 SHALL have port sdo  output  1  serial data, two's complement, MSB first.
REQ-012 SHALL have port frame_start  output  1  one-clk_en-tick pulse when a new frame loads.
REQ-013 SHALL have port overrun  output  1  sticky flag: a pending sample was overwritten before transmission.

Function
REQ-014 SHALL capture left/right into hold registers and set pending on any clk_en tick with sample high.
REQ-015 SHALL, if sample arrives while pending is already set, overwrite the hold registers and set overrun.
REQ-016 SHALL run a divider counting clk_en ticks 0..DIV-1 and toggle bclk on the tick the count is DIV-1, then wrap it to 0.
REQ-017 SHALL treat a bclk 1->0 toggle as a falling event; all of bitcnt, lrck, sdo and frame_start update only on the same tick as a falling event.
REQ-018 SHALL keep a 5-bit bitcnt, incremented on each falling event, wrapping 31->0; 32 bclk periods per frame.
REQ-019 SHALL, on the falling event where bitcnt becomes 0, load cur_l/cur_r from the hold registers and clear pending if pending is set; otherwise cur_l/cur_r retain the previous sample (repeat).
REQ-020 SHALL pulse frame_start high for exactly that one clk_en tick when the load in REQ-019 occurs, and not when the previous sample is repeated.
REQ-021 SHALL, if sample and a load falling event coincide, load the old hold contents, then capture the new pair into hold with pending left set; overrun SHALL NOT be set by this coincidence.
REQ-022 SHALL drive sdo = bit (15 - n mod 16) of cur_l for n<16 and of cur_r for n>=16, where n is the new bitcnt.
REQ-023 SHALL drive lrck = (n>=16) when FMT=0 and lrck = (((n+1) mod 32)>=16) when FMT=1.
REQ-024 SHALL present sdo stable across every bclk rising edge; sdo and lrck change only at falling events.
REQ-025 SHALL hold every state when clk_en is low; frame_start SHALL be low on any tick where clk_en is low.
REQ-026 SHALL give a latency from the sample tick to the MSB on sdo of at most one frame (32*2*DIV clk_en ticks) plus one falling event.

Reset
REQ-027 SHALL, on rst high at a clk edge regardless of clk_en, clear bclk, lrck, sdo, frame_start, overrun, pending, bitcnt (to 31), the divider, hold and cur registers.
REQ-028 SHALL make bitcnt 0, and load pending data, on the first falling event after reset, so the first frame always starts with the left MSB.
REQ-029 SHALL have rst asserted mid-frame abandon the frame and clear overrun; no partial word SHALL be emitted after rst falls.

Verification
REQ-030 SHALL be checked with DIV=2, FMT=0, clk_en=1, sample once with left=16'h8001 and right=16'h7FFE -> a frame_start pulse, then sdo bits 1000000000000001 with lrck=0, then 0111111111111110 with lrck=1, bclk period 4 clk.
REQ-031 SHALL be checked with FMT=1 and the same data -> lrck falls one bclk before the left MSB and rises one bclk before the right MSB.
REQ-032 SHALL be checked with two samples (16'h1234/16'h5678, then 16'hABCD/16'hEF01) within one frame -> overrun=1, the next frame carries ABCD/EF01, and 1234 is never transmitted.
REQ-033 SHALL be checked with no sample after the first frame -> the frame repeats identical bits and frame_start stays 0.
REQ-034 SHALL be checked with clk_en at 1-in-3 duty -> the bit sequence is identical to REQ-030 with timing scaled x3, and no output changes on ticks where clk_en=0.
REQ-035 SHALL be checked with rst for one cycle at bitcnt 20 -> all outputs are 0 next cycle, and the next frame starts the left MSB with overrun=0.
